// File: rtl/adder_share_ctrl_pkg.sv
// adder_share_ctrl_pkg
//   Shared definitions for the adder-sharing controller slice.
//   The macro block mirrors the shared define.v contents (operand size,
//   adder group size, controller state encodings). It is guarded so that a
//   project-wide define.v can supply the same names.
//   The package exposes the controller state type and default sizes.
`ifndef ADDER_SHARE_CTRL_DEFINES
`define ADDER_SHARE_CTRL_DEFINES
`ifndef INPUTSIZE
`define INPUTSIZE 16
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif
`define ADDCTRL_IDLE    2'b00
`define ADDCTRL_COMPUTE 2'b01
`define ADDCTRL_RESP    2'b10
`endif

package adder_share_ctrl_pkg;

  // Controller states; encodings come from the shared defines so that
  // other blocks decoding the state see the same values.
  typedef enum logic [1:0] {
    ST_IDLE    = `ADDCTRL_IDLE,
    ST_COMPUTE = `ADDCTRL_COMPUTE,
    ST_RESP    = `ADDCTRL_RESP
  } ctrl_state_e;

  localparam int DEF_WIDTH  = `INPUTSIZE;
  localparam int GROUP_SIZE = `GROUPSIZE;

endpackage

// File: rtl/Brent_Kung_Adder.sv
// Brent_Kung_Adder
//   Unsigned `INPUTSIZE-bit adder built on a Brent-Kung parallel prefix tree.
//   Ports:
//     A, B : operands (`INPUTSIZE bits)
//     cin  : carry-in (1 bit, vector form [0:0])
//     S    : sum with carry-out in the MSB (`INPUTSIZE+1 bits)
//   Purely combinational.
module Brent_Kung_Adder (
  input  logic [`INPUTSIZE-1:0] A,
  input  logic [`INPUTSIZE-1:0] B,
  input  logic [0:0]            cin,
  output logic [`INPUTSIZE:0]   S
);

  localparam int N   = `INPUTSIZE;
  localparam int L   = (N > 1) ? $clog2(N) : 1;
  // L up-sweep levels followed by L-1 down-sweep levels.
  localparam int NST = 2 * L - 1;

  logic [N:0] carry;

  // Each stage owns its own generate/propagate vectors; stage k reads
  // stage k-1 only, so there is no combinational self-dependency.
  for (genvar si = 0; si <= NST; si++) begin : g_stage
    logic [N-1:0] g_o;
    logic [N-1:0] p_o;
    if (si == 0) begin : g_init
      assign g_o = A & B;
      assign p_o = A ^ B;
    end else begin : g_step
      localparam int ST     = si - 1;
      localparam int LVL    = (ST < L) ? ST : (2 * L - 2 - ST);
      localparam int HALF   = 1 << LVL;
      localparam int STRIDE = 2 * HALF;
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        // Up-sweep combines at the top of every aligned block; the
        // down-sweep fills the midpoints left open by the up-sweep.
        localparam bit UP = (ST < L) && (((gi + 1) % STRIDE) == 0);
        localparam bit DN = (ST >= L) && (gi >= STRIDE) &&
                            (((gi + 1 - HALF) % STRIDE) == 0);
        if (UP || DN) begin : g_comb
          assign g_o[gi] = g_stage[si-1].g_o[gi] |
                           (g_stage[si-1].p_o[gi] & g_stage[si-1].g_o[gi-HALF]);
          assign p_o[gi] = g_stage[si-1].p_o[gi] & g_stage[si-1].p_o[gi-HALF];
        end else begin : g_pass
          assign g_o[gi] = g_stage[si-1].g_o[gi];
          assign p_o[gi] = g_stage[si-1].p_o[gi];
        end
      end
    end
  end

  // After the tree, bit i holds the group (generate, propagate) of [i:0].
  assign carry[0] = cin[0];
  for (genvar gi = 0; gi < N; gi++) begin : g_sum
    assign carry[gi+1] = g_stage[NST].g_o[gi] | (g_stage[NST].p_o[gi] & cin[0]);
    assign S[gi]       = g_stage[0].p_o[gi] ^ carry[gi];
  end
  assign S[N] = carry[N];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: grants the first requester at or after
//   ptr, searching circularly. The pointer register lives in the caller.
//   Ports:
//     req       : request vector (N bits)
//     ptr       : search start index (IDW bits)
//     en        : arbitration enable; no grant when low
//     grant     : one-hot grant or zero
//     grant_idx : index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  always_comb begin
    int  cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        cand = (int'(ptr) + k) % N;
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = IDW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Shares one Brent_Kung_Adder between NREQ requesters. A round-robin
//   arbiter picks one request per transaction; operands are registered
//   into the adder and the (WIDTH+1)-bit sum is returned on one response
//   channel tagged with the requester id.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     req_valid/req_ready : per-requester handshake (req_ready one-hot or 0)
//     req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//     rsp_valid/rsp_ready : response handshake
//     rsp_sum, rsp_id     : sum with carry-out in MSB, owning requester
//     ops_done            : wrapping count of response handshakes
//     busy                : high whenever the controller is not idle
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = `INPUTSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           ops_done,
  output logic                  busy
);

  ctrl_state_e      state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH:0]   rsp_sum_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic             rsp_valid_reg;
  logic [15:0]      ops_done_reg;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             arb_en;
  logic             accept;
  logic             rsp_hs;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH:0]   adder_s;

  logic [WIDTH-1:0] req_a_arr [NREQ];
  logic [WIDTH-1:0] req_b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign req_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // A new request can be taken when idle, or in RESP on the very cycle the
  // current result is consumed, giving back-to-back ops every two cycles.
  assign arb_en = (state_reg == ST_IDLE) ||
                  ((state_reg == ST_RESP) && rsp_ready);

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rsp_hs    = rsp_valid_reg & rsp_ready;
  assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Adder sees registered operands only.
  Brent_Kung_Adder u_adder (
    .A   (op_a_reg),
    .B   (op_b_reg),
    .cin (1'b0),
    .S   (adder_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      id_reg        <= '0;
      rsp_sum_reg   <= '0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      ops_done_reg  <= '0;
    end else begin
      // Counter is rewritten every cycle so it always reflects its own
      // current value plus the handshake.
      ops_done_reg <= ops_done_reg + {15'd0, rsp_hs};

      // Accept can only fire in IDLE or RESP (arb_en gates the arbiter).
      if (accept) begin
        op_a_reg <= req_a_arr[grant_idx];
        op_b_reg <= req_b_arr[grant_idx];
        id_reg   <= grant_idx;
        ptr_reg  <= ptr_next;
      end

      case (state_reg)
        ST_IDLE: begin
          if (accept) state_reg <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          rsp_sum_reg   <= adder_s;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= accept ? ST_COMPUTE : ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_id    = rsp_id_reg;
  assign ops_done  = ops_done_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A transaction-level model (one op in flight, round-robin
//   choice, latency counter, completion count) is checked every cycle.
module tb_adder_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a = '0;
  logic [NREQ*W-1:0]    req_b = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [W:0]           rsp_sum;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          ops_done;
  logic                 busy;

  always #5 clk = ~clk;

  adder_share_ctrl #(
    .NREQ  (NREQ),
    .IDW   (IDW),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .ops_done  (ops_done),
    .busy      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_inflight = 1'b0;
  int          m_age      = 0;   // edges since grant, counting the grant edge
  int          m_ptr      = 0;
  logic [W:0]  m_sum      = '0;
  int          m_id       = 0;
  logic [15:0] m_cnt      = '0;
  bit          ops_chk_off = 1'b0;
  bit          ops_load    = 1'b0;
  logic [15:0] ops_load_val = '0;

  always @(negedge clk) begin : compare
    bit              exp_rv;
    bit              can_acc;
    int              g;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    a;
    logic [W-1:0]    b;

    if (ops_load) begin
      m_cnt    = ops_load_val;
      ops_load = 1'b0;
    end

    exp_rv = m_inflight && (m_age >= 2);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_id", rsp_id, m_id);
    end

    can_acc = !m_inflight || (exp_rv && rsp_ready);
    g = -1;
    exp_rdy = '0;
    if (can_acc) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_inflight);
    if (!ops_chk_off) chk("ops_done", ops_done, m_cnt);

    // advance model across the coming clock edge
    if (rst) begin
      m_inflight = 1'b0;
      m_age      = 0;
      m_ptr      = 0;
      m_cnt      = '0;
    end else begin
      if (exp_rv && rsp_ready) begin
        m_cnt++;
        m_inflight = 1'b0;
        $display("rsp id=%0d sum=%05h ops_done_next=%0d", rsp_id, rsp_sum, m_cnt);
      end
      if (m_inflight) m_age++;
      if (g >= 0) begin
        a          = req_a[g*W +: W];
        b          = req_b[g*W +: W];
        m_sum      = {1'b0, a} + {1'b0, b};
        m_id       = g;
        m_ptr      = (g + 1) % NREQ;
        m_inflight = 1'b1;
        m_age      = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]   = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Ends on a negedge with the DUT idle (or a reported timeout).
  task automatic wait_idle(input string name);
    int n = 0;
    smp();
    while (busy && n < 20) begin
      cyc();
      smp();
      n++;
    end
    if (busy) tmo(name);
  endtask

  // Issues one op on requester i and returns just after its response edge.
  task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    cyc();
    set_req(i, a, b);
    smp();
    while (!req_ready[i] && n < 10) begin
      cyc();
      smp();
      n++;
    end
    if (!req_ready[i]) tmo("do_op_grant");
    cyc();
    req_valid[i] = 1'b0;
    n = 0;
    smp();
    while (!(rsp_valid && rsp_ready) && n < 10) begin
      cyc();
      smp();
      n++;
    end
    if (!(rsp_valid && rsp_ready)) tmo("do_op_rsp");
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] hs;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int ngr, last_c, cycn, gidx;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    smp();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);

    // ---- single op on req0 ----
    cyc();
    set_req(0, 16'h1234, 16'h0001);
    smp();
    chk("t1_ready_pulse", req_ready, 4'b0001);
    cyc();
    req_valid[0] = 1'b0;
    smp();
    chk("t1_ready_drop", req_ready, 4'b0000);
    chk("t1_compute_no_rsp", rsp_valid, 0);
    cyc();
    smp();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_sum", rsp_sum, 17'h01235);
    chk("t1_rsp_id", rsp_id, 0);
    cyc();
    smp();
    chk("t1_ops_done", ops_done, 1);
    chk("t1_rsp_drop", rsp_valid, 0);

    // ---- carry-out on req2 ----
    cyc();
    set_req(2, 16'hFFFF, 16'h0001);
    smp();
    chk("t2_ready", req_ready, 4'b0100);
    cyc();
    req_valid[2] = 1'b0;
    cyc();
    smp();
    chk("t2_rsp_sum", rsp_sum, 17'h10000);
    chk("t2_rsp_id", rsp_id, 2);
    cyc();
    smp();
    chk("t2_ops_done", ops_done, 2);

    // ---- round robin from a fresh pointer ----
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
    ngr = 0;
    last_c = 0;
    cycn = 0;
    while (ngr < 5 && cycn < 30) begin
      smp();
      hs = req_valid & req_ready;
      if (hs != '0) begin
        gidx = onehot_idx(hs);
        chk("t3_grant_order", gidx, exp_order[ngr]);
        if (ngr > 0) chk("t3_grant_spacing", cycn - last_c, 2);
        last_c = cycn;
        ngr++;
      end
      cyc();
      cycn++;
      for (int i = 0; i < NREQ; i++) if (hs[i]) set_req(i, rnd_op(), rnd_op());
    end
    if (ngr < 5) tmo("t3_round_robin");
    req_valid = '0;
    wait_idle("t3_drain");

    // ---- backpressure with req1 waiting ----
    cyc();
    rsp_ready = 1'b0;
    set_req(3, 16'h8000, 16'h8001);
    smp();
    chk("t4_ready3", req_ready, 4'b1000);
    cyc();
    req_valid[3] = 1'b0;
    set_req(1, 16'h0F0F, 16'h0101);
    smp();
    chk("t4_compute_ready", req_ready, 4'b0000);
    cyc();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t4_bp_ready", req_ready, 4'b0000);
      chk("t4_bp_valid", rsp_valid, 1);
      chk("t4_bp_sum", rsp_sum, 17'h10001);
      chk("t4_bp_id", rsp_id, 3);
      cyc();
    end
    rsp_ready = 1'b1;
    smp();
    chk("t4_release_ready", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    smp();
    chk("t4_req1_sum", rsp_sum, 17'h01010);
    chk("t4_req1_id", rsp_id, 1);
    wait_idle("t4_drain");

    // ---- reset in COMPUTE ----
    cyc();
    set_req(0, 16'h00AA, 16'h0055);
    smp();
    chk("t5_ready0", req_ready, 4'b0001);
    cyc();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    smp();
    chk("t5_busy_compute", busy, 1);
    cyc();
    rst = 1'b0;
    smp();
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ops_done", ops_done, 0);
    chk("t5_rsp_sum", rsp_sum, 0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_req_ready", req_ready, 0);
    repeat (3) begin
      cyc();
      smp();
      chk("t5_no_rsp", rsp_valid, 0);
    end
    cyc();
    set_req(0, 16'h0002, 16'h0002);
    set_req(1, 16'h0001, 16'h0001);
    smp();
    chk("t5_ptr_from_zero", req_ready, 4'b0001);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    smp();
    chk("t5_rsp_sum_after", rsp_sum, 17'h00004);
    chk("t5_rsp_id_after", rsp_id, 0);
    chk("t5_req1_backtoback", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 1'b0;
    wait_idle("t5_drain");

    // ---- ops_done wrap ----
    cyc();
    ops_chk_off = 1'b1;
    force dut.ops_done_reg = 16'hFFFE;
    cyc();
    cyc();
    release dut.ops_done_reg;
    ops_load_val = 16'hFFFE;
    ops_load     = 1'b1;
    ops_chk_off  = 1'b0;
    smp();
    chk("t6_preload", ops_done, 16'hFFFE);
    do_op(2, 16'h0001, 16'h0002);
    smp();
    chk("t6_ffff", ops_done, 16'hFFFF);
    do_op(3, 16'h0003, 16'h0004);
    smp();
    chk("t6_wrap", ops_done, 16'h0000);

    // ---- randomized traffic ----
    cyc();
    for (int c = 0; c < 2000; c++) begin
      smp();
      hs = req_valid & req_ready;
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rnd_op(), rnd_op());
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
